// File: rtl/pcie_multilane_scrambler.sv
// Gen1/Gen2 multi-lane TX scrambler: per-lane LFSR with COM/SKP
// handling, TS ordered-set bypass window and fixed 2-cycle latency.
module pcie_multilane_scrambler #(
    parameter int NUM_LANES   = 4,
    parameter int MAX_BYTES   = 4,
    parameter int OS_DATA_LEN = 15
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [5:0]                       pipe_width_i,
    input  logic                             scramble_dis_i,
    input  logic                             data_valid_i,
    input  logic [NUM_LANES*MAX_BYTES*8-1:0] data_i,
    input  logic [NUM_LANES*MAX_BYTES-1:0]   data_k_i,
    output logic                             data_valid_o,
    output logic [NUM_LANES*MAX_BYTES*8-1:0] data_o,
    output logic [NUM_LANES*MAX_BYTES-1:0]   data_k_o
);

    localparam int NB = NUM_LANES * MAX_BYTES;
    localparam int CW = $clog2(OS_DATA_LEN + 1);
    localparam logic [7:0]  SYM_COM = 8'hBC;
    localparam logic [7:0]  SYM_SKP = 8'h1C;
    localparam logic [15:0] SEED    = 16'hFFFF;

    typedef struct packed {
        logic [15:0]   lfsr;
        logic          pend;
        logic [CW-1:0] cnt;
    } lane_st_t;

    // returns {scrambled byte, LFSR after 8 shifts}
    function automatic logic [23:0] scr_byte(input logic [15:0] s,
                                             input logic [7:0]  d);
        logic [15:0] l;
        logic [7:0]  o;
        l = s;
        o = '0;
        for (int j = 0; j < 8; j++) begin
            o[j] = d[j] ^ l[15];
            l    = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
        end
        return {o, l};
    endfunction

    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rst_sync_q <= '0;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    logic [2:0] nb_d;

    always_comb begin
        nb_d = 3'd1;
        case (pipe_width_i)
            6'd16:   if (MAX_BYTES >= 2) nb_d = 3'd2;
            6'd32:   if (MAX_BYTES >= 4) nb_d = 3'd4;
            default: nb_d = 3'd1;
        endcase
    end

    logic          v1_q;
    logic          dis1_q;
    logic [2:0]    nb1_q;
    logic [NB*8-1:0] d1_q;
    logic [NB-1:0]   k1_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            dis1_q <= 1'b0;
            nb1_q  <= 3'd1;
            d1_q   <= '0;
            k1_q   <= '0;
        end else begin
            v1_q <= data_valid_i;
            if (data_valid_i) begin
                dis1_q <= scramble_dis_i;
                nb1_q  <= nb_d;
                d1_q   <= data_i;
                k1_q   <= data_k_i;
            end
        end
    end

    lane_st_t        st_q [NUM_LANES];
    lane_st_t        st_d [NUM_LANES];
    lane_st_t        cur;
    logic [NB*8-1:0] dout_d;
    logic [NB-1:0]   kout_d;
    logic [7:0]      sym;
    logic [7:0]      scr;
    logic [15:0]     adv;
    logic            kf;

    always_comb begin
        st_d   = st_q;
        dout_d = '0;
        kout_d = '0;
        cur    = '0;
        sym    = '0;
        scr    = '0;
        adv    = '0;
        kf     = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            cur = st_q[l];
            for (int b = 0; b < MAX_BYTES; b++) begin
                if (v1_q && b < int'(nb1_q)) begin
                    sym = d1_q[(l*MAX_BYTES+b)*8 +: 8];
                    kf  = k1_q[l*MAX_BYTES+b];
                    {scr, adv} = scr_byte(cur.lfsr, sym);
                    kout_d[l*MAX_BYTES+b] = kf;
                    dout_d[(l*MAX_BYTES+b)*8 +: 8] = sym;
                    if (kf && sym == SYM_COM) begin
                        cur.lfsr = SEED;
                        cur.pend = 1'b1;
                    end else if (!(kf && sym == SYM_SKP)) begin
                        // SKP falls through untouched: LFSR frozen, window kept
                        cur.lfsr = adv;
                        if (kf) begin
                            if (cur.pend) begin
                                cur.pend = 1'b0;
                                cur.cnt  = '0;
                            end
                        end else if (cur.pend) begin
                            cur.pend = 1'b0;
                            cur.cnt  = CW'(OS_DATA_LEN - 1);
                        end else if (cur.cnt != '0) begin
                            cur.cnt = cur.cnt - CW'(1);
                        end else if (!dis1_q) begin
                            dout_d[(l*MAX_BYTES+b)*8 +: 8] = scr;
                        end
                    end
                end
            end
            st_d[l] = cur;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                st_q[l] <= {SEED, 1'b0, {CW{1'b0}}};
            end
            data_valid_o <= 1'b0;
            data_o       <= '0;
            data_k_o     <= '0;
        end else begin
            data_valid_o <= v1_q;
            data_o       <= dout_d;
            data_k_o     <= kout_d;
            if (v1_q) st_q <= st_d;
        end
    end

endmodule

// File: tb/tb_pcie_multilane_scrambler.sv
// Directed bench for pcie_multilane_scrambler: constant vectors plus
// a per-lane reference model for the mixed-traffic stretch.
module tb_pcie_multilane_scrambler;

    localparam int NL  = 4;
    localparam int MB  = 4;
    localparam int OSL = 15;
    localparam int DW  = NL * MB * 8;
    localparam int KW  = NL * MB;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic [5:0]    pipe_width_i = 6'd8;
    logic          scramble_dis_i = 1'b0;
    logic          data_valid_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic [KW-1:0] data_k_i = '0;
    logic          data_valid_o;
    logic [DW-1:0] data_o;
    logic [KW-1:0] data_k_o;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] got_d [$];
    logic [KW-1:0] got_k [$];
    logic [DW-1:0] exp_d [$];
    logic [KW-1:0] exp_k [$];
    logic [7:0]    ib [$];
    logic          ik [$];
    logic [7:0]    eb [$];

    bit          vchk = 1'b0;
    logic [1:0]  vhist = 2'b00;

    logic [15:0] m_lfsr [NL];
    logic        m_pend [NL];
    int          m_cnt  [NL];

    always #5 clk_i = ~clk_i;

    pcie_multilane_scrambler #(
        .NUM_LANES  (NL),
        .MAX_BYTES  (MB),
        .OS_DATA_LEN(OSL)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pipe_width_i  (pipe_width_i),
        .scramble_dis_i(scramble_dis_i),
        .data_valid_i  (data_valid_i),
        .data_i        (data_i),
        .data_k_i      (data_k_i),
        .data_valid_o  (data_valid_o),
        .data_o        (data_o),
        .data_k_o      (data_k_o)
    );

    always @(negedge clk_i) begin
        if (data_valid_o) begin
            got_d.push_back(data_o);
            got_k.push_back(data_k_o);
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_byte(input logic [15:0] s,
                                             input logic [7:0]  d);
        logic [7:0] o;
        logic       fb;
        o = '0;
        for (int j = 0; j < 8; j++) begin
            o[j] = d[j] ^ s[15];
            fb   = s[15];
            s    = {s[14:0], 1'b0};
            if (fb) begin
                s[5:3] = s[5:3] ^ 3'b111;
                s[0]   = ~s[0];
            end
        end
        return {o, s};
    endfunction

    function automatic logic [7:0] prbs(input int n);
        logic [15:0] s;
        logic [7:0]  o;
        s = 16'hFFFF;
        o = '0;
        for (int i = 0; i <= n; i++) {o, s} = ref_byte(s, 8'h00);
        return o;
    endfunction

    task automatic m_sym(input int l, input logic [7:0] d, input logic k,
                         output logic [7:0] o);
        logic [7:0]  p;
        logic [15:0] s;
        o = d;
        if (k && d == 8'hBC) begin
            m_lfsr[l] = 16'hFFFF;
            m_pend[l] = 1'b1;
        end else if (!(k && d == 8'h1C)) begin
            {p, s} = ref_byte(m_lfsr[l], d);
            m_lfsr[l] = s;
            if (k) begin
                if (m_pend[l]) begin
                    m_pend[l] = 1'b0;
                    m_cnt[l]  = 0;
                end
            end else if (m_pend[l]) begin
                m_pend[l] = 1'b0;
                m_cnt[l]  = OSL - 1;
            end else if (m_cnt[l] > 0) begin
                m_cnt[l]--;
            end else begin
                o = p;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d,
                         input logic [KW-1:0] k);
        @(negedge clk_i);
        if (vchk) check("valid_o", DW'(data_valid_o), DW'(vhist[1]));
        vhist = {vhist[0], v};
        data_valid_i = v;
        data_i = d;
        data_k_i = k;
    endtask

    task automatic flush();
        repeat (3) drive(1'b0, '0, '0);
    endtask

    task automatic add(input logic [7:0] d, input logic k,
                       input logic [7:0] e);
        ib.push_back(d);
        ik.push_back(k);
        eb.push_back(e);
    endtask

    // inactive byte slots carry AA/K=1 junk that must come out as zero
    task automatic run_stream(input int nb);
        for (int w = 0; w < ib.size() / nb; w++) begin
            logic [31:0] dw, ew;
            logic [3:0]  kw, ekw;
            dw = 32'hAAAAAAAA;
            kw = 4'hF;
            ew = '0;
            ekw = '0;
            for (int b = 0; b < nb; b++) begin
                dw[b*8 +: 8] = ib[w*nb+b];
                kw[b]        = ik[w*nb+b];
                ew[b*8 +: 8] = eb[w*nb+b];
                ekw[b]       = ik[w*nb+b];
            end
            exp_d.push_back({NL{ew}});
            exp_k.push_back({NL{ekw}});
            drive(1'b1, {NL{dw}}, {NL{kw}});
        end
        ib.delete();
        ik.delete();
        eb.delete();
        flush();
    endtask

    task automatic check_q(input string tag);
        check({tag, "_cnt"}, DW'(got_d.size()), DW'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            check($sformatf("%s_d%0d", tag, i), got_d[i], exp_d[i]);
            check($sformatf("%s_k%0d", tag, i), DW'(got_k[i]), DW'(exp_k[i]));
        end
        got_d.delete();
        got_k.delete();
        exp_d.delete();
        exp_k.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_valid", DW'(data_valid_o), '0);
        check("rst_data", data_o, '0);
        check("rst_k", DW'(data_k_o), '0);
        rst_ni = 1'b1;
        flush();

        // width 8: COM, IDL closes window, then D00 stream
        pipe_width_i = 6'd8;
        add(8'hBC, 1, 8'hBC);
        add(8'h7C, 1, 8'h7C);
        add(8'h00, 0, 8'h17);
        add(8'h00, 0, 8'hC0);
        add(8'h00, 0, 8'h14);
        add(8'h00, 0, 8'hB2);
        add(8'h00, 0, 8'hE7);
        add(8'h00, 0, 8'h02);
        add(8'h00, 0, 8'h82);
        add(8'h00, 0, 8'h72);
        run_stream(1);
        check_q("t1");

        // COM inside an open window restarts it
        add(8'hBC, 1, 8'hBC);
        add(8'h33, 0, 8'h33);
        add(8'h33, 0, 8'h33);
        add(8'hBC, 1, 8'hBC);
        for (int i = 0; i < 15; i++) add(8'h55, 0, 8'h55);
        add(8'h00, 0, 8'h8D);
        add(8'h00, 0, prbs(16));
        run_stream(1);
        check_q("t1r");

        // width 32: TS body passes, then sequence resumes at byte 16
        pipe_width_i = 6'd32;
        add(8'hBC, 1, 8'hBC);
        for (int i = 0; i < 15; i++) add(8'(8'h20 + i), 0, 8'(8'h20 + i));
        add(8'h00, 0, 8'h8D);
        for (int i = 16; i < 19; i++) add(8'h00, 0, prbs(i));
        run_stream(4);
        check_q("t2");

        // width 16: SKP OS freezes LFSR
        pipe_width_i = 6'd16;
        add(8'hBC, 1, 8'hBC);
        add(8'h1C, 1, 8'h1C);
        add(8'h1C, 1, 8'h1C);
        add(8'h1C, 1, 8'h1C);
        add(8'h7C, 1, 8'h7C);
        add(8'h00, 0, 8'h17);
        add(8'h00, 0, 8'hC0);
        add(8'h00, 0, 8'h14);
        add(8'hBC, 1, 8'hBC);
        add(8'h1C, 1, 8'h1C);
        add(8'h55, 0, 8'h55);
        add(8'h00, 0, 8'h00);
        run_stream(2);
        check_q("t3");

        // scramble disable: data passes, LFSR keeps running
        pipe_width_i = 6'd32;
        scramble_dis_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            add(r, 0, r);
        end
        add(8'hBC, 1, 8'hBC);
        add(8'h7C, 1, 8'h7C);
        add(8'h5A, 0, 8'h5A);
        add(8'h00, 0, 8'h00);
        run_stream(4);
        scramble_dis_i = 1'b0;
        add(8'h00, 0, 8'h14);
        add(8'h00, 0, 8'hB2);
        add(8'h00, 0, 8'hE7);
        add(8'h00, 0, 8'h02);
        run_stream(4);
        check_q("t4");

        // independent lanes, random gaps, reference model
        for (int l = 0; l < NL; l++) begin
            m_lfsr[l] = 16'hFFFF;
            m_pend[l] = 1'b0;
            m_cnt[l]  = 0;
        end
        vchk = 1'b1;
        begin
            bit first;
            first = 1'b1;
            for (int w = 0; w < 60; w++) begin
                logic          v;
                logic [DW-1:0] dw, ew;
                logic [KW-1:0] kw;
                logic [7:0]    sym, o;
                logic          ks;
                int            r;
                v = first || ($urandom_range(0, 3) != 0);
                dw = '0;
                ew = '0;
                kw = '0;
                for (int l = 0; l < NL; l++) begin
                    for (int b = 0; b < MB; b++) begin
                        r = $urandom_range(0, 19);
                        if (first && b == 0) r = 0;
                        ks = 1'b1;
                        case (r)
                            0: sym = 8'hBC;
                            1: sym = 8'h1C;
                            2: sym = 8'h7C;
                            3: sym = 8'hFB;
                            default: begin
                                sym = 8'($urandom_range(0, 255));
                                ks = 1'b0;
                            end
                        endcase
                        dw[(l*MB+b)*8 +: 8] = sym;
                        kw[l*MB+b] = ks;
                        if (v) begin
                            m_sym(l, sym, ks, o);
                            ew[(l*MB+b)*8 +: 8] = o;
                        end
                    end
                end
                if (v) begin
                    exp_d.push_back(ew);
                    exp_k.push_back(kw);
                    first = 1'b0;
                end
                drive(v, dw, kw);
            end
        end
        flush();
        vchk = 1'b0;
        check_q("t5");

        // reset mid-window
        pipe_width_i = 6'd8;
        drive(1'b1, {NL{32'hAAAAAABC}}, {NL{4'b1111}});
        drive(1'b1, {NL{32'hAAAAAA11}}, {NL{4'b1110}});
        drive(1'b1, {NL{32'hAAAAAA22}}, {NL{4'b1110}});
        check("t6_pre_valid", DW'(data_valid_o), DW'(1));
        #2 rst_ni = 1'b0;
        #1;
        check("t6_rst_valid", DW'(data_valid_o), '0);
        check("t6_rst_data", data_o, '0);
        check("t6_rst_k", DW'(data_k_o), '0);
        data_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        flush();
        got_d.delete();
        got_k.delete();
        add(8'h00, 0, 8'hFF);
        add(8'h00, 0, 8'h17);
        run_stream(1);
        check_q("t6");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
